// File: rtl/instr_pkg.sv
// instr_pkg: shared RV32 field positions, NOP encoding and decoded-field struct
package instr_pkg;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam int OPC_LSB  = 0;
    localparam int RD_LSB   = 7;
    localparam int FUN3_LSB = 12;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int FUN7_LSB = 25;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [24:0] instr_31_7;
    } instr_fields_t;
endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: splits a 32-bit word into RV32 fields, substituting the NOP when bubbled
module instr_field_split
    import instr_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic          bubble,
    output instr_fields_t fields
);
    logic [31:0] w;
    always_comb begin
        w = bubble ? NOP_INSTR : instr;
        fields.opcode     = w[OPC_LSB+:7];
        fields.fun3       = w[FUN3_LSB+:3];
        fields.fun7       = w[FUN7_LSB+:7];
        fields.rs1        = w[RS1_LSB+:5];
        fields.rs2        = w[RS2_LSB+:5];
        fields.rd         = w[RD_LSB+:5];
        fields.instr_31_7 = w[31:RD_LSB];
    end
endmodule

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode circular instruction queue presenting the head as decoded RV32 fields
module instr_queue
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid_in,
    output logic              in_ready_o,
    input  logic [31:0]       instr_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid_o,
    input  logic              out_ready_in,
    output logic [6:0]        opcode_o,
    output logic [2:0]        fun_3_o,
    output logic [6:0]        fun_7_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [24:0]       instr_31_7_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]      instr_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    instr_fields_t    head;
    assign in_ready_o  = (count != CNT_W'(DEPTH)) && !flush_in;
    assign out_valid_o = (count != '0) && !flush_in;
    assign push        = in_valid_in && in_ready_o;
    assign pop         = out_valid_o && out_ready_in;
    assign count_o     = count;
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk_in) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_in;
            pc_mem[wr_ptr]    <= pc_in;
        end
    end
    instr_field_split u_split (
        .instr  (instr_mem[rd_ptr]),
        .bubble (!out_valid_o),
        .fields (head)
    );
    assign opcode_o     = head.opcode;
    assign fun_3_o      = head.fun3;
    assign fun_7_o      = head.fun7;
    assign rs1_addr_o   = head.rs1;
    assign rs2_addr_o   = head.rs2;
    assign rd_addr_o    = head.rd;
    assign instr_31_7_o = head.instr_31_7;
    assign pc_o         = out_valid_o ? pc_mem[rd_ptr] : '0;
    assign illegal_o    = out_valid_o && (instr_mem[rd_ptr][1:0] != 2'b11);
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized and directed scoreboard bench for instr_queue
module tb_instr_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic clk_in = 0, rst_in = 1, flush_in = 0, in_valid_in = 0, out_ready_in = 0;
    logic [31:0] instr_in = '0;
    logic [PC_W-1:0] pc_in = '0;
    logic in_ready_o, out_valid_o, illegal_o;
    logic [6:0] opcode_o, fun_7_o;
    logic [2:0] fun_3_o;
    logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [24:0] instr_31_7_o;
    logic [PC_W-1:0] pc_o;
    logic [CNT_W-1:0] count_o;
    int n_cmp = 0, n_bad = 0;
    bit armed = 0;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t exp_q[$];

    instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid_in(in_valid_in), .in_ready_o(in_ready_o),
        .instr_in(instr_in), .pc_in(pc_in),
        .out_valid_o(out_valid_o), .out_ready_in(out_ready_in),
        .opcode_o(opcode_o), .fun_3_o(fun_3_o), .fun_7_o(fun_7_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .instr_31_7_o(instr_31_7_o), .pc_o(pc_o), .illegal_o(illegal_o),
        .count_o(count_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the scoreboard, then applies this cycle's handshakes to it
    always @(negedge clk_in) begin
        bit vexp, rexp;
        logic [31:0] w, p;
        if (armed) begin
            vexp = exp_q.size() != 0 && !flush_in;
            rexp = exp_q.size() != DEPTH && !flush_in;
            w = vexp ? exp_q[0].instr : 32'h0000_0013;
            p = vexp ? exp_q[0].pc : 32'h0;
            chk("count", 64'(count_o), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready_o), 64'(rexp));
            chk("out_valid", 64'(out_valid_o), 64'(vexp));
            chk("opcode", 64'(opcode_o), 64'(w[6:0]));
            chk("fun3", 64'(fun_3_o), 64'(w[14:12]));
            chk("fun7", 64'(fun_7_o), 64'(w[31:25]));
            chk("rs1", 64'(rs1_addr_o), 64'(w[19:15]));
            chk("rs2", 64'(rs2_addr_o), 64'(w[24:20]));
            chk("rd", 64'(rd_addr_o), 64'(w[11:7]));
            chk("instr_31_7", 64'(instr_31_7_o), 64'(w[31:7]));
            chk("pc", 64'(pc_o), 64'(p));
            chk("illegal", 64'(illegal_o), 64'(vexp && w[1:0] != 2'b11));
            if (rst_in || flush_in) exp_q.delete();
            else begin
                if (vexp && out_ready_in) void'(exp_q.pop_front());
                if (in_valid_in && rexp) exp_q.push_back({pc_in, instr_in});
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] i, input logic [31:0] p,
                        input bit o, input bit f, input bit r);
        in_valid_in = v; instr_in = i; pc_in = p;
        out_ready_in = o; flush_in = f; rst_in = r;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(3) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    initial begin
        logic [31:0] w5;
        @(posedge clk_in);
        #1;
        armed = 1;
        step(0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(1, 32'h00A2_8293, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(1, rnd_instr(), 32'h200 + 4 * k, 0, 0, 0);
        w5 = rnd_instr();
        step(1, w5, 32'h210, 0, 0, 0);
        step(1, w5, 32'h210, 1, 0, 0);
        step(1, w5, 32'h210, 1, 0, 0);
        repeat (6) step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) step(1, rnd_instr(), 32'h300 + 4 * k, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(1, rnd_instr(), 32'h308 + 4 * k, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(1, rnd_instr(), 32'h400 + 4 * k, 0, 0, 0);
        step(1, rnd_instr(), 32'h40c, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h0000_4501, 32'h500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, rnd_instr(), 32'h504, 0, 0, 0);
        step(1, rnd_instr(), 32'h508, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++)
            step($urandom_range(3) != 0, rnd_instr(), $urandom, $urandom_range(2) != 0,
                 $urandom_range(19) == 0, $urandom_range(49) == 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
